peri_timer_bank: RTL and testbench

Memory-mapped bank of `N_TIMER` independent reload timers, plus a free-running cycle counter and an aggregated interrupt, for the MIPS pipeline's peripheral address space (0x4000_xxxx). It replaces the single hard-wired timer in the data-memory peripheral array. Each channel adds a prescaler, one-shot/periodic mode and write-1-to-clear pending flags. Register reads are synchronous, with one cycle of latency, matching the data-memory read path.

---
 rtl/peri_timer_bank_if.sv | 24 ++
 rtl/peri_timer_bank.sv | 155 +++++++++++++++
 tb/tb_peri_timer_bank.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/peri_timer_bank_if.sv
// Peripheral bus between the MIPS data-memory path and the timer bank.
// The master drives the strobes and address; the slave returns read data and interrupts.
interface peri_timer_bank_if #(
    parameter int N_TIMER = 4
);
    logic               sel;
    logic [31:0]        Address;
    logic [31:0]        Write_data;
    logic               MemWrite;
    logic               MemRead;
    logic [31:0]        Read_data;
    logic [N_TIMER-1:0] irq_vec;
    logic               irq;

    modport master (
        output sel, Address, Write_data, MemWrite, MemRead,
        input  Read_data, irq_vec, irq
    );

    modport slave (
        input  sel, Address, Write_data, MemWrite, MemRead,
        output Read_data, irq_vec, irq
    );
endinterface

// File: rtl/peri_timer_bank.sv
// Bank of N_TIMER prescaled reload timers with a free-running cycle counter and
// an aggregated interrupt, mapped into the 0x4000_xxxx peripheral space.
module peri_timer_chan #(
    parameter int TIMER_W = 32,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_reload,
    input  logic               wr_count,
    input  logic               wr_ctrl,
    input  logic               wr_presc,
    input  logic [31:0]        wdata,
    output logic [TIMER_W-1:0] reload,
    output logic [TIMER_W-1:0] count,
    output logic [3:0]         ctrl,
    output logic [PRESC_W-1:0] presc
);
    logic [PRESC_W-1:0] pc;
    logic               en, ie, pend, oneshot;
    logic               tick, ovf;
    wire                unused_wd = &{1'b0, wdata};

    assign tick = en && (pc == presc);
    // A COUNT write discards the tick, so it cannot overflow either.
    assign ovf  = tick && (&count) && !wr_count;
    assign ctrl = {oneshot, pend, ie, en};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload  <= '0;
            count   <= '0;
            presc   <= '0;
            pc      <= '0;
            en      <= 1'b0;
            ie      <= 1'b0;
            pend    <= 1'b0;
            oneshot <= 1'b0;
        end else begin
            if (wr_reload) reload <= wdata[TIMER_W-1:0];
            if (wr_presc)  presc  <= wdata[PRESC_W-1:0];

            if (wr_count)  count <= wdata[TIMER_W-1:0];
            else if (tick) count <= (&count) ? reload : count + 1'b1;

            if (wr_presc || wr_ctrl || !en || tick) pc <= '0;
            else                                    pc <= pc + 1'b1;

            if (wr_ctrl) begin
                en      <= wdata[0];
                ie      <= wdata[1];
                oneshot <= wdata[3];
            end else if (ovf && oneshot) begin
                en      <= 1'b0;
            end

            // Overflow set dominates a same-cycle write-1-to-clear.
            pend <= ovf | (pend & ~(wr_ctrl & wdata[2]));
        end
    end
endmodule

module peri_timer_bank #(
    parameter int N_TIMER = 4,
    parameter int TIMER_W = 32,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    peri_timer_bank_if.slave  bus
);
    localparam logic [6:0] STATUS_OFF = 7'(4 * N_TIMER);
    localparam logic [6:0] CYCLES_OFF = 7'(4 * N_TIMER + 1);

    logic [N_TIMER-1:0][TIMER_W-1:0] r_reload, r_count;
    logic [N_TIMER-1:0][3:0]         r_ctrl;
    logic [N_TIMER-1:0][PRESC_W-1:0] r_presc;
    logic [N_TIMER-1:0]              wr_reload, wr_count, wr_ctrl, wr_presc;
    logic [N_TIMER-1:0]              pend_vec, irq_next;
    logic [31:0]                     cycles, rdata;
    logic [5:0]                      word;
    logic                            wr;
    wire                             unused = &{1'b0, bus.Address[31:8], bus.Address[1:0], bus.MemRead};

    assign word = bus.Address[7:2];
    assign wr   = bus.sel && bus.MemWrite;

    always_comb begin
        wr_reload = '0;
        wr_count  = '0;
        wr_ctrl   = '0;
        wr_presc  = '0;
        for (int i = 0; i < N_TIMER; i++) begin
            if (wr && word[5:2] == i[3:0]) begin
                wr_reload[i] = (word[1:0] == 2'd0);
                wr_count[i]  = (word[1:0] == 2'd1);
                wr_ctrl[i]   = (word[1:0] == 2'd2);
                wr_presc[i]  = (word[1:0] == 2'd3);
            end
        end
    end

    for (genvar g = 0; g < N_TIMER; g++) begin : g_chan
        peri_timer_chan #(.TIMER_W(TIMER_W), .PRESC_W(PRESC_W)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .wr_reload (wr_reload[g]),
            .wr_count  (wr_count[g]),
            .wr_ctrl   (wr_ctrl[g]),
            .wr_presc  (wr_presc[g]),
            .wdata     (bus.Write_data),
            .reload    (r_reload[g]),
            .count     (r_count[g]),
            .ctrl      (r_ctrl[g]),
            .presc     (r_presc[g])
        );
        assign pend_vec[g] = r_ctrl[g][2];
        assign irq_next[g] = r_ctrl[g][2] & r_ctrl[g][1];
    end

    // Read mux sees pre-edge register values, so a same-cycle write reads old data.
    always_comb begin
        rdata = '0;
        if ({1'b0, word} == STATUS_OFF) begin
            rdata = 32'(pend_vec);
        end else if ({1'b0, word} == CYCLES_OFF) begin
            rdata = cycles;
        end else begin
            for (int i = 0; i < N_TIMER; i++) begin
                if (word[5:2] == i[3:0]) begin
                    case (word[1:0])
                        2'd0:    rdata = 32'(r_reload[i]);
                        2'd1:    rdata = 32'(r_count[i]);
                        2'd2:    rdata = 32'(r_ctrl[i]);
                        default: rdata = 32'(r_presc[i]);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles        <= '0;
            bus.Read_data <= '0;
            bus.irq_vec   <= '0;
            bus.irq       <= 1'b0;
        end else begin
            cycles        <= cycles + 32'd1;
            bus.Read_data <= bus.sel ? rdata : 32'd0;
            bus.irq_vec   <= irq_next;
            bus.irq       <= |irq_next;
        end
    end
endmodule

// File: tb/tb_peri_timer_bank.sv
// Directed bench: a 32-bit-counter bank and an 8-bit-counter bank share one stimulus bus.
module tb_peri_timer_bank;
    logic        clk, reset;
    logic        sel, mem_write, mem_read;
    logic [31:0] addr, wdata;
    logic [31:0] rd32, rd8, c1;
    int          n_chk, n_err;

    peri_timer_bank_if #(.N_TIMER(4)) bus32 ();
    peri_timer_bank_if #(.N_TIMER(4)) bus8 ();

    assign bus32.sel = sel;  assign bus32.Address = addr;  assign bus32.Write_data = wdata;
    assign bus32.MemWrite = mem_write;  assign bus32.MemRead = mem_read;
    assign bus8.sel = sel;   assign bus8.Address = addr;   assign bus8.Write_data = wdata;
    assign bus8.MemWrite = mem_write;   assign bus8.MemRead = mem_read;

    peri_timer_bank #(.N_TIMER(4), .TIMER_W(32), .PRESC_W(16)) dut32 (
        .clk(clk), .reset(reset), .bus(bus32));
    peri_timer_bank #(.N_TIMER(4), .TIMER_W(8), .PRESC_W(16)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        sel = 1'b1; mem_write = 1'b1; mem_read = 1'b0; addr = 32'(off) << 2; wdata = d;
        cyc(1);
        sel = 1'b0; mem_write = 1'b0;
    endtask

    task automatic rd(input int off, input logic s);
        sel = s; mem_write = 1'b0; mem_read = 1'b1; addr = 32'(off) << 2;
        cyc(1);
        rd32 = bus32.Read_data; rd8 = bus8.Read_data;
        sel = 1'b0; mem_read = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        reset = 1'b1; sel = 1'b0; mem_write = 1'b0; mem_read = 1'b0; addr = '0; wdata = '0;
        #12;
        check("rst_rdata", bus32.Read_data, 32'h0);
        check("rst_irq", {31'b0, bus32.irq}, 32'h0);
        check("rst_irqvec8", {28'b0, bus8.irq_vec}, 32'h0);
        reset = 1'b0;
        cyc(1);

        // periodic: overflow every 4 ticks, W1C drops irq one edge later
        wr(0, 32'hFFFF_FFFC); wr(1, 32'hFFFF_FFFC); wr(3, 0); wr(2, 32'h3);
        cyc(4);
        check("per_irq_pre", {31'b0, bus32.irq}, 32'h0);
        rd(16, 1'b1);
        check("per_status", rd32, 32'h1);
        check("per_irq", {31'b0, bus32.irq}, 32'h1);
        rd(1, 1'b1);
        check("per_count", rd32, 32'hFFFF_FFFD);
        wr(2, 32'h7);
        check("w1c_irq_k", {31'b0, bus32.irq}, 32'h1);
        cyc(1);
        check("w1c_irq_k1", {31'b0, bus32.irq}, 32'h0);
        cyc(1);
        check("per_irq_again", {31'b0, bus32.irq}, 32'h1);
        wr(2, 32'h4);

        // prescaler and one-shot on the 8-bit bank, channel 1
        wr(4, 32'h10); wr(5, 32'hFE); wr(7, 32'h2); wr(6, 32'h9);
        cyc(3);
        rd(5, 1'b1);
        check("os_count_ff", rd8, 32'hFF);
        cyc(2);
        rd(5, 1'b1);
        check("os_count_rel", rd8, 32'h10);
        rd(6, 1'b1);
        check("os_ctrl", rd8, 32'hC);
        cyc(3);
        rd(5, 1'b1);
        check("os_hold", rd8, 32'h10);
        wr(6, 32'h4);

        // COUNT write on a tick edge wins
        wr(1, 32'h10); wr(2, 32'h1); wr(1, 32'h55);
        rd(1, 1'b1);
        check("col_count", rd32, 32'h55);
        wr(2, 32'h0);

        // W1C on the overflow edge leaves PEND set
        wr(0, 32'h0); wr(1, 32'hFFFF_FFFE); wr(2, 32'h1);
        cyc(1);
        wr(2, 32'h5);
        rd(2, 1'b1);
        check("col_w1c", rd32, 32'h5);
        wr(2, 32'h4);

        // ch0 and ch2 overflow on the same edge
        wr(1, 32'hFFFF_FFFE); wr(9, 32'hFFFF_FFFF); wr(2, 32'h3); wr(10, 32'h3);
        cyc(1);
        rd(16, 1'b1);
        check("mc_status", rd32, 32'h5);
        check("mc_irqvec", {28'b0, bus32.irq_vec}, 32'h5);
        check("mc_irq", {31'b0, bus32.irq}, 32'h1);
        wr(2, 32'h6);
        cyc(1);
        check("mc_irqvec_clr", {28'b0, bus32.irq_vec}, 32'h4);
        check("mc_irq_clr", {31'b0, bus32.irq}, 32'h1);

        // read path
        rd(20, 1'b1);
        check("rd_unmapped", rd32, 32'h0);
        rd(16, 1'b1);
        check("rd_status", rd32, 32'h4);
        rd(16, 1'b0);
        check("rd_nosel", rd32, 32'h0);
        rd(17, 1'b1);
        c1 = rd32;
        wr(17, 32'h1234_5678);
        rd(17, 1'b1);
        check("cycles_ro", rd32, c1 + 32'd2);

        // asynchronous reset mid-count
        #2 reset = 1'b1;
        #1;
        check("arst_rdata", bus32.Read_data, 32'h0);
        check("arst_irq", {31'b0, bus32.irq}, 32'h0);
        check("arst_irqvec", {28'b0, bus32.irq_vec}, 32'h0);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd(17, 1'b1);
            check($sformatf("cycles_%0d", k), rd32, 32'(k));
        end
        for (int o = 0; o < 17; o++) begin
            rd(o, 1'b1);
            check($sformatf("arst_reg%0d", o), rd32, 32'h0);
        end
        check("arst_irq_after", {31'b0, bus32.irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
